vector_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the vector custom-instruction unit.
- Accepts one vector operation per request handshake and executes it on a narrow, time-multiplexed element datapath (LANES elements per cycle) rather than a full-width combinational array.
- Returns the packed result vector through a response handshake.
- Sits between the decode/issue stage and the writeback to the vector register file.

---
 rtl/vseq_pkg.sv | 29 ++
 rtl/vseq_lane_alu.sv | 27 ++
 rtl/vector_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_vector_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vseq_pkg.sv
// Shared definitions for the vector sequencer: operation/mode encodings,
// FSM state encoding and the vl port width helper.
package vseq_pkg;

  // Operand-B source selection
  localparam logic [1:0] MODE_VV  = 2'b00;
  localparam logic [1:0] MODE_VX  = 2'b01;
  localparam logic [1:0] MODE_VI  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Element operations; anything above OP_OR is illegal
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // vl must encode 0..VECTOR_LENGTH inclusive
  function automatic int vl_width(input int vlen);
    return $clog2(vlen + 1);
  endfunction

endpackage

// File: rtl/vseq_lane_alu.sv
// Single-element combinational ALU used by each lane of the vector sequencer.
// All arithmetic wraps modulo 2^DATA_WIDTH; mul keeps the low half.
module vseq_lane_alu
  import vseq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] y
);

  // Element operation select; illegal codes produce zero
  always_comb begin
    y = '0;
    case (funct3)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_seq_ctrl.sv
// Multi-cycle vector operation sequencer. Accepts one op per request
// handshake, evaluates LANES elements per EXEC cycle through a shared set of
// lane ALUs and returns the packed result through a response handshake.
// Optional build macro VSEQ_MASK_EN adds the vmask input: active elements
// with a clear mask bit keep operand A's element instead of the op result.
// LANES must divide VECTOR_LENGTH.
module vector_seq_ctrl
  import vseq_pkg::*;
#(
  parameter  int VECTOR_LENGTH = 8,
  parameter  int DATA_WIDTH    = 32,
  parameter  int LANES         = 2,
  localparam int VL_W          = vl_width(VECTOR_LENGTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_a,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_b,
  input  logic [DATA_WIDTH-1:0]               scalar,
  input  logic [1:0]                          mode,
  input  logic [2:0]                          funct3,
  input  logic [VL_W-1:0]                     vl,
`ifdef VSEQ_MASK_EN
  input  logic [VECTOR_LENGTH-1:0]            vmask,
`endif
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [VECTOR_LENGTH*DATA_WIDTH-1:0] result,
  output logic                                resp_err,
  output logic                                busy
);

  localparam int              IDX_W   = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam logic [VL_W-1:0] VL_MAX  = VL_W'(VECTOR_LENGTH);
  localparam logic [VL_W-1:0] LANES_V = VL_W'(LANES);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q   [VECTOR_LENGTH];
  logic [DATA_WIDTH-1:0]   a_d   [VECTOR_LENGTH];
  logic [DATA_WIDTH-1:0]   b_q   [VECTOR_LENGTH];
  logic [DATA_WIDTH-1:0]   b_d   [VECTOR_LENGTH];
  logic [DATA_WIDTH-1:0]   res_q [VECTOR_LENGTH];
  logic [DATA_WIDTH-1:0]   res_d [VECTOR_LENGTH];
  logic [DATA_WIDTH-1:0]   scalar_q, scalar_d;
  logic [1:0]              mode_q, mode_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [VL_W-1:0]         vl_q, vl_d;
  logic [VL_W-1:0]         idx_q, idx_d;
  logic                    err_q, err_d;
`ifdef VSEQ_MASK_EN
  logic [VECTOR_LENGTH-1:0] mask_q, mask_d;
`endif

  // Per-lane datapath signals
  logic [VL_W-1:0]         lane_pos [LANES];
  logic [IDX_W-1:0]        lane_sel [LANES];
  logic [DATA_WIDTH-1:0]   lane_a   [LANES];
  logic [DATA_WIDTH-1:0]   lane_b   [LANES];
  logic [DATA_WIDTH-1:0]   lane_y   [LANES];
  logic [DATA_WIDTH-1:0]   lane_out [LANES];

  // Accept-time decode of the incoming request
  logic                    req_illegal;
  logic [VL_W-1:0]         vl_clamped;

  assign req_illegal = (funct3 > OP_OR) || (mode == MODE_RSV);
  assign vl_clamped  = (vl > VL_MAX) ? VL_MAX : vl;

  // Lane gi handles element idx+gi of the current group; elements past vl
  // are forced to zero so the tail of the result stays clean.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_pos[gi] = idx_q + VL_W'(gi);
    assign lane_sel[gi] = lane_pos[gi][IDX_W-1:0];
    assign lane_a[gi]   = a_q[lane_sel[gi]];
    assign lane_b[gi]   = (mode_q == MODE_VV) ? b_q[lane_sel[gi]] : scalar_q;

    vseq_lane_alu #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
      .a      (lane_a[gi]),
      .b      (lane_b[gi]),
      .funct3 (funct3_q),
      .y      (lane_y[gi])
    );

`ifdef VSEQ_MASK_EN
    assign lane_out[gi] = (lane_pos[gi] >= vl_q)   ? '0 :
                          mask_q[lane_sel[gi]]     ? lane_y[gi] : lane_a[gi];
`else
    assign lane_out[gi] = (lane_pos[gi] < vl_q) ? lane_y[gi] : '0;
`endif
  end

  // Flatten the result register onto the packed output bus
  for (genvar gi = 0; gi < VECTOR_LENGTH; gi++) begin : g_pack
    assign result[gi*DATA_WIDTH +: DATA_WIDTH] = res_q[gi];
  end

  assign resp_err = err_q;

  // Next-state, datapath next values and handshake outputs
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    scalar_d   = scalar_q;
    mode_d     = mode_q;
    funct3_d   = funct3_q;
    vl_d       = vl_q;
    idx_d      = idx_q;
    err_d      = err_q;
`ifdef VSEQ_MASK_EN
    mask_d     = mask_q;
`endif
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          for (int e = 0; e < VECTOR_LENGTH; e++) begin
            a_d[e]   = vector_a[e*DATA_WIDTH +: DATA_WIDTH];
            b_d[e]   = vector_b[e*DATA_WIDTH +: DATA_WIDTH];
            res_d[e] = '0;
          end
          scalar_d = scalar;
          mode_d   = mode;
          funct3_d = funct3;
          vl_d     = vl_clamped;
          idx_d    = '0;
          err_d    = req_illegal;
`ifdef VSEQ_MASK_EN
          mask_d   = vmask;
`endif
          // Illegal ops and empty vectors skip straight to the response
          if (req_illegal || (vl_clamped == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          res_d[lane_sel[l]] = lane_out[l];
        end
        idx_d = idx_q + LANES_V;
        if ((idx_q + LANES_V) >= vl_q) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      for (int e = 0; e < VECTOR_LENGTH; e++) begin
        a_q[e]   <= '0;
        b_q[e]   <= '0;
        res_q[e] <= '0;
      end
      scalar_q <= '0;
      mode_q   <= MODE_VV;
      funct3_q <= OP_ADD;
      vl_q     <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
`ifdef VSEQ_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      scalar_q <= scalar_d;
      mode_q   <= mode_d;
      funct3_q <= funct3_d;
      vl_q     <= vl_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
`ifdef VSEQ_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_vector_seq_ctrl.sv
// Scoreboard bench for vector_seq_ctrl: the driver pushes model results at
// accept time, the monitor pops and compares on each response handshake.
module tb_vector_seq_ctrl;

  localparam int VL  = 8;
  localparam int DW  = 32;
  localparam int LN  = 2;
  localparam int VLW = 4;
  localparam int VW  = VL * DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [VW-1:0]  vector_a = '0;
  logic [VW-1:0]  vector_b = '0;
  logic [DW-1:0]  scalar = '0;
  logic [1:0]     mode = '0;
  logic [2:0]     funct3 = '0;
  logic [VLW-1:0] vl = '0;
  logic [VL-1:0]  vmask = '1;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [VW-1:0]  result;
  logic           resp_err;
  logic           busy;

  typedef struct {
    logic [VW-1:0] res;
    logic          err;
    int            acc;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cyc = 0;
  int   issue_cnt = 0;
  int   resp_cnt = 0;
  int   rr_mode = 2;   // 0 random, 1 hold low, 2 hold high

  vector_seq_ctrl #(
    .VECTOR_LENGTH (VL),
    .DATA_WIDTH    (DW),
    .LANES         (LN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .vector_a   (vector_a),
    .vector_b   (vector_b),
    .scalar     (scalar),
    .mode       (mode),
    .funct3     (funct3),
    .vl         (vl),
`ifdef VSEQ_MASK_EN
    .vmask      (vmask),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic fail_now(input string nm);
    chk_cnt++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference: element-wise arithmetic straight from the operation rules
  function automatic exp_t model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic [DW-1:0] s, input logic [1:0] m,
                                 input logic [2:0] f, input logic [VLW-1:0] v,
                                 input logic [VL-1:0] mk);
    exp_t e;
    int n;
    logic [DW-1:0] x, y, z;
    e.res = '0;
    e.acc = 0;
    e.err = (f > 3'd4) || (m == 2'd3);
    n = (int'(v) > VL) ? VL : int'(v);
    if (!e.err) begin
      for (int i = 0; i < n; i++) begin
        x = a[i*DW +: DW];
        y = (m == 2'd0) ? b[i*DW +: DW] : s;
        case (f)
          3'd0:    z = x + y;
          3'd1:    z = x - y;
          3'd2:    z = x * y;
          3'd3:    z = x & y;
          default: z = x | y;
        endcase
`ifdef VSEQ_MASK_EN
        if (!mk[i]) z = x;
`else
        if (mk == '0) z = z;
`endif
        e.res[i*DW +: DW] = z;
      end
    end
    e.lat = (e.err || n == 0) ? 1 : (n + LN - 1) / LN + 1;
    return e;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < VL; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the accepting edge
  task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic [DW-1:0] s, input logic [1:0] m,
                       input logic [2:0] f, input logic [VLW-1:0] v,
                       input logic [VL-1:0] mk);
    bit got;
    got = 0;
    vector_a = a; vector_b = b; scalar = s; mode = m; funct3 = f; vl = v; vmask = mk;
    req_valid = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_t e;
        e = model(a, b, s, m, f, v, mk);
        e.acc = cyc;
        exp_q.push_back(e);
        issue_cnt++;
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    // Garbage on the operand inputs must not disturb the op in flight
    vector_a = rand_vec(); vector_b = rand_vec(); scalar = $urandom;
    mode = 2'($urandom); funct3 = 3'($urandom); vl = VLW'($urandom); vmask = VL'($urandom);
    if (!got) fail_now("accept_timeout");
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // resp_ready generator
  initial forever begin
    @(posedge clk);
    #2;
    case (rr_mode)
      0:       resp_ready = ($urandom_range(0, 3) != 0);
      1:       resp_ready = 1'b0;
      default: resp_ready = 1'b1;
    endcase
  end

  // Monitor: latency on first valid, stability while stalled, data on handshake
  initial begin
    bit seen;
    logic [VW-1:0] held;
    seen = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", {{(VW-1){1'b0}}, resp_valid}, '0);
        end else begin
          if (!seen) begin
            seen = 1;
            held = result;
            chk("latency", VW'(cyc - exp_q[0].acc), VW'(exp_q[0].lat));
            chk("req_ready_in_done", VW'(req_ready), VW'(0));
          end else begin
            chk("hold_stable", result, held);
          end
          if (resp_ready) begin
            chk("result", result, exp_q[0].res);
            chk("resp_err", VW'(resp_err), VW'(exp_q[0].err));
            void'(exp_q.pop_front());
            resp_cnt++;
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] va, vb;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", VW'(req_ready), VW'(1));
    chk("rst_resp_valid", VW'(resp_valid), VW'(0));
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_resp_err", VW'(resp_err), VW'(0));
    chk("rst_result", result, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // VV add, vl=8, a[i]=i, b[i]=10
    for (int i = 0; i < VL; i++) begin
      va[i*DW +: DW] = DW'(i);
      vb[i*DW +: DW] = 32'd10;
    end
    issue(va, vb, '0, 2'd0, 3'd0, 4'd8, '1);

    // VX mul, scalar=3, a[i]=0x4000_0001 -> 0xC000_0003
    for (int i = 0; i < VL; i++) va[i*DW +: DW] = 32'h4000_0001;
    issue(va, rand_vec(), 32'd3, 2'd1, 3'd2, 4'd8, '1);

    // VX sub wrap, a=0, scalar=1
    issue('0, rand_vec(), 32'd1, 2'd1, 3'd1, 4'd8, '1);

    // VV or with short vl: tail stays zero
    issue(rand_vec(), rand_vec(), '0, 2'd0, 3'd4, 4'd3, '1);

    // Illegal funct3, reserved mode, empty vector
    issue(rand_vec(), rand_vec(), $urandom, 2'd0, 3'd6, 4'd8, '1);
    issue(rand_vec(), rand_vec(), $urandom, 2'd3, 3'd0, 4'd8, '1);
    issue(rand_vec(), rand_vec(), $urandom, 2'd1, 3'd0, 4'd0, '1);

    // Clamp of vl beyond the vector length
    issue(rand_vec(), rand_vec(), $urandom, 2'd2, 3'd0, 4'd13, '1);

`ifdef VSEQ_MASK_EN
    // Mask: odd elements keep operand A
    issue(rand_vec(), rand_vec(), '0, 2'd0, 3'd0, 4'd8, 8'h55);
`endif
    drain();

    // Response stalled in DONE: result must hold, req_ready low
    rr_mode = 1;
    issue(rand_vec(), rand_vec(), $urandom, 2'd2, 3'd3, 4'd7, '1);
    for (int t = 0; t < 50 && !resp_valid; t++) @(negedge clk);
    if (!resp_valid) fail_now("stall_wait_valid");
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rr_mode = 2;
    drain();

    // Request pulse during EXEC must be ignored
    issue(rand_vec(), rand_vec(), '0, 2'd0, 3'd1, 4'd8, '1);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    vl = 4'd2;
    funct3 = 3'd0;
    @(negedge clk);
    chk("exec_req_ready", VW'(req_ready), VW'(0));
    chk("exec_busy", VW'(busy), VW'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();

    // Reset during EXEC aborts the op with no response
    issue(rand_vec(), rand_vec(), '0, 2'd0, 3'd0, 4'd8, '1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    issue_cnt--;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_resp_valid", VW'(resp_valid), VW'(0));
    chk("abort_req_ready", VW'(req_ready), VW'(1));
    chk("abort_result", result, '0);
    @(posedge clk);
    #1;

    // Randomized ops with random backpressure
    rr_mode = 0;
    for (int n = 0; n < 40; n++) begin
      logic [1:0] m;
      logic [2:0] f;
      m = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      issue(rand_vec(), rand_vec(), $urandom, m, f, VLW'($urandom_range(0, 15)), VL'($urandom));
    end
    rr_mode = 2;
    drain();

    chk("resp_count", VW'(resp_cnt), VW'(issue_cnt));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
